// File: rtl/leaf_user_bridge.sv
// Buffered vld/ack bridge between BFT leaf user streams and one HLS operator, plus run controller.
// Optional: define BRIDGE_WORD_CNT_EN to add per-output-channel word counters on port word_cnt.
module leaf_user_bridge_fifo #(
  parameter int W   = 32,
  parameter int DL2 = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  input  logic         vld_in,
  output logic         ack_in,
  output logic [W-1:0] dout,
  output logic         vld_out,
  input  logic         ack_out
);
  localparam int unsigned DEPTH = 1 << DL2;

  logic [W-1:0]   mem_q [DEPTH];
  logic [DL2-1:0] wr_q, rd_q;
  logic [DL2:0]   cnt_q;
  logic           wr, rd;

  // occupancy tops out at exactly DEPTH, so its MSB alone flags full
  assign ack_in  = ~cnt_q[DL2];
  assign vld_out = (cnt_q != '0);
  assign dout    = vld_out ? mem_q[rd_q] : '0;
  assign wr      = vld_in & ack_in;
  assign rd      = vld_out & ack_out;

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wr_q <= wr_q + 1'b1;
      if (rd) rd_q <= rd_q + 1'b1;
      case ({wr, rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module leaf_user_bridge #(
  parameter int PAYLOAD_BITS = 32,
  parameter int N_IN         = 2,
  parameter int N_OUT        = 4,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          op_start,
  input  logic                          op_done,
  input  logic [N_IN*PAYLOAD_BITS-1:0]  din_if,
  input  logic [N_IN-1:0]               vld_if,
  output logic [N_IN-1:0]               ack_if,
  output logic [N_IN*PAYLOAD_BITS-1:0]  dout_op,
  output logic [N_IN-1:0]               vld_op,
  input  logic [N_IN-1:0]               ack_op,
  input  logic [N_OUT*PAYLOAD_BITS-1:0] din_op,
  input  logic [N_OUT-1:0]              vld_opo,
  output logic [N_OUT-1:0]              ack_opo,
  output logic [N_OUT*PAYLOAD_BITS-1:0] dout_if,
  output logic [N_OUT-1:0]              vld_ifo,
  input  logic [N_OUT-1:0]              ack_ifo
`ifdef BRIDGE_WORD_CNT_EN
  ,
  output logic [N_OUT*32-1:0]           word_cnt
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e state_q;
  logic   op_start_q, busy_q, done_q;
  logic   run_entry;
  logic   outs_empty;

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    leaf_user_bridge_fifo #(.W(PAYLOAD_BITS), .DL2(DEPTH_LOG2)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (din_if[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .vld_in  (vld_if[k]),
      .ack_in  (ack_if[k]),
      .dout    (dout_op[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .vld_out (vld_op[k]),
      .ack_out (ack_op[k])
    );
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    leaf_user_bridge_fifo #(.W(PAYLOAD_BITS), .DL2(DEPTH_LOG2)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (din_op[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .vld_in  (vld_opo[k]),
      .ack_in  (ack_opo[k]),
      .dout    (dout_if[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .vld_out (vld_ifo[k]),
      .ack_out (ack_ifo[k])
    );
  end

  assign run_entry  = (state_q == S_IDLE) && start;
  assign outs_empty = ~|vld_ifo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_RUN;
          op_start_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        S_RUN: if (op_done) begin
          state_q    <= S_DRAIN;
          op_start_q <= 1'b0;
        end
        S_DRAIN: if (outs_empty) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign op_start = op_start_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef BRIDGE_WORD_CNT_EN
  logic [31:0] wcnt_q [N_OUT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < N_OUT; k++) wcnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (run_entry)
          wcnt_q[k] <= '0;
        else if (vld_ifo[k] && ack_ifo[k] && (wcnt_q[k] != '1))
          wcnt_q[k] <= wcnt_q[k] + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    assign word_cnt[k*32 +: 32] = wcnt_q[k];
  end
`endif
endmodule

// File: tb/tb_leaf_user_bridge.sv
// Scoreboard bench for leaf_user_bridge; word_cnt checks only when BRIDGE_WORD_CNT_EN is defined.
module tb_leaf_user_bridge;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         op_done = 1'b0;
  logic         busy, done, op_start;
  logic [63:0]  din_if = '0;
  logic [1:0]   vld_if = '0;
  logic [1:0]   ack_if;
  logic [63:0]  dout_op;
  logic [1:0]   vld_op;
  logic [1:0]   ack_op = '0;
  logic [127:0] din_op = '0;
  logic [3:0]   vld_opo = '0;
  logic [3:0]   ack_opo;
  logic [127:0] dout_if;
  logic [3:0]   vld_ifo;
  logic [3:0]   ack_ifo = '0;
`ifdef BRIDGE_WORD_CNT_EN
  logic [127:0] word_cnt;
`endif

  int total = 0;
  int bad = 0;
  bit rand_mode = 1'b0;
  logic [31:0] qin  [2][$];
  logic [31:0] qout [4][$];

  leaf_user_bridge #(.PAYLOAD_BITS(32), .N_IN(2), .N_OUT(4), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .op_start(op_start), .op_done(op_done),
    .din_if(din_if), .vld_if(vld_if), .ack_if(ack_if),
    .dout_op(dout_op), .vld_op(vld_op), .ack_op(ack_op),
    .din_op(din_op), .vld_opo(vld_opo), .ack_opo(ack_opo),
    .dout_if(dout_if), .vld_ifo(vld_ifo), .ack_ifo(ack_ifo)
`ifdef BRIDGE_WORD_CNT_EN
    , .word_cnt(word_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", tag, got, exp);
    end
  endtask

  // Transfers are decided by levels held stable across the negedge before the edge.
  always @(negedge clk) if (reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (vld_op[k] && ack_op[k]) begin
        if (qin[k].size() == 0) chk("in_unexpected_vld", 32'(vld_op[k]), 32'd0);
        else chk("in_data", dout_op[k*32 +: 32], qin[k].pop_front());
      end
      if (vld_if[k] && ack_if[k]) qin[k].push_back(din_if[k*32 +: 32]);
    end
    for (int k = 0; k < 4; k++) begin
      if (vld_ifo[k] && ack_ifo[k]) begin
        if (qout[k].size() == 0) chk("out_unexpected_vld", 32'(vld_ifo[k]), 32'd0);
        else chk("out_data", dout_if[k*32 +: 32], qout[k].pop_front());
      end
      if (vld_opo[k] && ack_opo[k]) qout[k].push_back(din_op[k*32 +: 32]);
    end
  end

  always begin
    @(posedge clk); #1;
    if (rand_mode) begin
      ack_op  = 2'($urandom);
      ack_ifo = 4'($urandom);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_in(input int k, input logic [31:0] w);
    int n = 0;
    din_if[k*32 +: 32] = w;
    vld_if[k] = 1'b1;
    @(negedge clk);
    while (!ack_if[k] && n < 500) begin @(negedge clk); n++; end
    if (!ack_if[k]) chk("in_push_timeout", 32'(ack_if[k]), 32'd1);
    @(posedge clk); #1;
    vld_if[k] = 1'b0;
  endtask

  task automatic push_opo(input int k, input logic [31:0] w);
    int n = 0;
    din_op[k*32 +: 32] = w;
    vld_opo[k] = 1'b1;
    @(negedge clk);
    while (!ack_opo[k] && n < 500) begin @(negedge clk); n++; end
    if (!ack_opo[k]) chk("opo_push_timeout", 32'(ack_opo[k]), 32'd1);
    @(posedge clk); #1;
    vld_opo[k] = 1'b0;
  endtask

  task automatic drive_in(input int k);
    for (int i = 0; i < 1000; i++) begin
      cyc($urandom_range(0, 2));
      push_in(k, $urandom);
    end
  endtask

  task automatic drive_opo(input int k);
    for (int i = 0; i < 1000; i++) begin
      cyc($urandom_range(0, 2));
      push_opo(k, $urandom);
    end
  endtask

  task automatic pulse_op_done();
    op_done = 1'b1;
    cyc(1);
    op_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int pulses = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (done) begin
        pulses++;
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      end
    end
    chk({tag, "_done_pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    cyc(2);
    chk("rst_op_start", 32'(op_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack_if", 32'(ack_if), 32'h3);
    chk("rst_ack_opo", 32'(ack_opo), 32'hF);
    chk("rst_vld_op", 32'(vld_op), 32'd0);
    chk("rst_vld_ifo", 32'(vld_ifo), 32'd0);
    chk("rst_dout_op", 32'(|dout_op), 32'd0);
    chk("rst_dout_if", 32'(|dout_if), 32'd0);
`ifdef BRIDGE_WORD_CNT_EN
    chk("rst_word_cnt", 32'(|word_cnt), 32'd0);
`endif
    reset_n = 1'b1;
    cyc(1);

    // single-word latency
    push_in(0, 32'hA5A5_0001);
    chk("lat_vld_op0", 32'(vld_op[0]), 32'd1);
    chk("lat_dout_op0", dout_op[31:0], 32'hA5A5_0001);
    ack_op[0] = 1'b1;
    cyc(1);
    ack_op[0] = 1'b0;
    chk("lat_drained", 32'(vld_op[0]), 32'd0);

    // fill to depth 4, fifth word held off until the operator drains
    for (int i = 1; i <= 4; i++) push_in(0, 32'h1000_0000 + 32'(i));
    chk("full_ack_if0", 32'(ack_if[0]), 32'd0);
    fork
      push_in(0, 32'h1000_0005);
      begin
        cyc(3);
        chk("full_hold_ack_if0", 32'(ack_if[0]), 32'd0);
        chk("full_hold_q", 32'(qin[0].size()), 32'd4);
        ack_op[0] = 1'b1;
      end
    join
    cyc(8);
    chk("full_all_out", 32'(qin[0].size()), 32'd0);
    ack_op = '0;

    // run: operator emits 3 words on ch2 while the leaf is stalled
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("run_op_start", 32'(op_start), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) push_opo(2, 32'hC0DE_0000 + 32'(i));
    chk("run_vld_ifo2", 32'(vld_ifo[2]), 32'd1);
    pulse_op_done();
    chk("drain_op_start", 32'(op_start), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    cyc(5);
    chk("drain_hold_busy", 32'(busy), 32'd1);
    chk("drain_hold_done", 32'(done), 32'd0);
    ack_ifo[2] = 1'b1;
    wait_done("run1");
    chk("run1_out_empty", 32'(qout[2].size()), 32'd0);
    chk("run1_idle_busy", 32'(busy), 32'd0);

    // op_done outside RUN has no effect
    pulse_op_done();
    cyc(1);
    chk("idle_opdone_busy", 32'(busy), 32'd0);
    chk("idle_opdone_op_start", 32'(op_start), 32'd0);

    // asynchronous reset mid-run with data queued
    ack_ifo = '0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    push_in(1, 32'hDEAD_0001);
    push_in(1, 32'hDEAD_0002);
    push_opo(0, 32'hBEEF_0001);
    push_opo(0, 32'hBEEF_0002);
    chk("mid_vld_op1", 32'(vld_op[1]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld_op", 32'(vld_op), 32'd0);
    chk("mid_rst_vld_ifo", 32'(vld_ifo), 32'd0);
    chk("mid_rst_op_start", 32'(op_start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 2; k++) qin[k].delete();
    for (int k = 0; k < 4; k++) qout[k].delete();
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    chk("post_rst_vld_op", 32'(vld_op), 32'd0);
    chk("post_rst_vld_ifo", 32'(vld_ifo), 32'd0);
    chk("post_rst_ack_if", 32'(ack_if), 32'h3);
    ack_op = '1;
    ack_ifo = '1;
    cyc(3);

    // randomly throttled traffic on every channel
    rand_mode = 1'b1;
    fork
      drive_in(0);
      drive_in(1);
      drive_opo(0);
      drive_opo(1);
      drive_opo(2);
      drive_opo(3);
    join
    rand_mode = 1'b0;
    cyc(1);
    ack_op = '1;
    ack_ifo = '1;
    cyc(12);
    for (int k = 0; k < 2; k++) chk("rand_in_left", 32'(qin[k].size()), 32'd0);
    for (int k = 0; k < 4; k++) chk("rand_out_left", 32'(qout[k].size()), 32'd0);

`ifdef BRIDGE_WORD_CNT_EN
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 7; i++) push_opo(1, 32'h7700_0000 + 32'(i));
    pulse_op_done();
    wait_done("cnt_run");
    chk("cnt_ch1", word_cnt[63:32], 32'd7);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("cnt_clear_ch1", word_cnt[63:32], 32'd0);
    pulse_op_done();
    wait_done("cnt_run2");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
